// File: rtl/sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// sobel_line_buffer
//
// Purpose:
//   Buffers the two most recent rows of a raster-order grayscale pixel stream.
//   For every pixel from the third row of a frame onward, it emits the three
//   vertically aligned pixels of that column: (r-2, c), (r-1, c) and (r, c).
//   The outputs connect port-to-port to the d0_i/d1_i/d2_i/done_i inputs of
//   sobel_data_modulate. No arithmetic and no border padding happen here.
//
// Parameters:
//   ROWS        image height in pixels (>= 3)
//   COLS        image width in pixels (>= 2), sets line-buffer depth
//   DATA_WIDTH  pixel width
//
// Ports:
//   clk          single clock, rising edge
//   rst          synchronous active-low reset
//   data_i       input pixel, raster order
//   done_i       data_i valid this cycle
//   d0_o         pixel at (r-2, c), oldest row
//   d1_o         pixel at (r-1, c)
//   d2_o         pixel at (r, c), the pixel just accepted
//   done_o       d0_o..d2_o valid this cycle
//   frame_end_o  one-cycle pulse with the last valid triple of a frame
// -----------------------------------------------------------------------------
module sobel_line_buffer #(
    parameter int ROWS       = 5,
    parameter int COLS       = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  done_i,
    output logic [DATA_WIDTH-1:0] d0_o,
    output logic [DATA_WIDTH-1:0] d1_o,
    output logic [DATA_WIDTH-1:0] d2_o,
    output logic                  done_o,
    output logic                  frame_end_o
);

    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;

    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_OUT = ROW_W'(2);

    // lb0 holds row r-1, lb1 holds row r-2, both indexed by the column counter.
    logic [DATA_WIDTH-1:0] lb0 [COLS];
    logic [DATA_WIDTH-1:0] lb1 [COLS];

    logic [COL_W-1:0] col;
    logic [ROW_W-1:0] row;

    logic col_wrap;
    logic row_wrap;

    assign col_wrap = (col == COL_LAST);
    assign row_wrap = (row == ROW_LAST);

    // NOTE: the line buffers have no reset. Clearing them would cost a write
    // port per entry and buys nothing: done_o is gated until two fresh rows
    // have been written, so stale contents never reach the outputs. Keeping
    // them in their own reset-free block also lets them map to RAM.
    always_ff @(posedge clk) begin
        if (rst && done_i) begin
            // NOTE: non-blocking assignments make both writes see the old
            // lb0[col], so the row shifts down one buffer instead of data_i
            // landing in both.
            lb1[col] <= lb0[col];
            lb0[col] <= data_i;
        end
    end

    // Counters and registered outputs. The output reads below use the same
    // pre-update buffer contents as the writes above (read-before-write).
    always_ff @(posedge clk) begin
        if (!rst) begin
            col         <= '0;
            row         <= '0;
            d0_o        <= '0;
            d1_o        <= '0;
            d2_o        <= '0;
            done_o      <= 1'b0;
            frame_end_o <= 1'b0;
        end else if (done_i) begin
            d0_o        <= lb1[col];
            d1_o        <= lb0[col];
            d2_o        <= data_i;
            done_o      <= (row >= ROW_FIRST_OUT);
            frame_end_o <= row_wrap && col_wrap;

            if (col_wrap) begin
                col <= '0;
                // Wrapping row after the last pixel lets the next frame start
                // on the following valid cycle without a reset.
                row <= row_wrap ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end else begin
            // Idle cycle: counters and data outputs hold, strobes drop.
            done_o      <= 1'b0;
            frame_end_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sobel_line_buffer.sv
// -----------------------------------------------------------------------------
// tb_sobel_line_buffer
//
// Directed testbench for sobel_line_buffer with ROWS=5, COLS=6, DATA_WIDTH=8.
// Each frame feeds pixel values base+p for p = 0..29 in raster order. For an
// accepted pixel p in rows 2..4 the expected triple is
// (base+p-12, base+p-6, base+p); rows 0 and 1 produce no done_o.
// -----------------------------------------------------------------------------
module tb_sobel_line_buffer;

    localparam int ROWS       = 5;
    localparam int COLS       = 6;
    localparam int DATA_WIDTH = 8;
    localparam int NPIX       = ROWS * COLS;        // 30
    localparam int FIRST_OUT  = 2 * COLS;           // 12
    localparam int NVALID     = (ROWS - 2) * COLS;  // 18

    logic                  clk;
    logic                  rst;
    logic [DATA_WIDTH-1:0] data_i;
    logic                  done_i;
    logic [DATA_WIDTH-1:0] d0_o;
    logic [DATA_WIDTH-1:0] d1_o;
    logic [DATA_WIDTH-1:0] d2_o;
    logic                  done_o;
    logic                  frame_end_o;

    int checks   = 0;
    int failures = 0;

    sobel_line_buffer #(
        .ROWS       (ROWS),
        .COLS       (COLS),
        .DATA_WIDTH (DATA_WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_i      (data_i),
        .done_i      (done_i),
        .d0_o        (d0_o),
        .d1_o        (d1_o),
        .d2_o        (d2_o),
        .done_o      (done_o),
        .frame_end_o (frame_end_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply inputs, let one rising edge pass, and return 1 time unit later so
    // outputs are sampled away from the edge and reflect the applied input.
    task automatic drive(input logic valid, input logic [DATA_WIDTH-1:0] value);
        done_i = valid;
        data_i = value;
        @(posedge clk);
        #1;
    endtask

    // One full frame of base+p, optionally with 3 idle cycles after every
    // 4th pixel. Checks every cycle against the expected stream.
    task automatic run_frame(input int base, input bit gaps, input string tag);
        int n_valid = 0;
        int n_end   = 0;
        logic [DATA_WIDTH-1:0] e0, e1, e2;
        logic e_end;
        for (int p = 0; p < NPIX; p++) begin
            drive(1'b1, DATA_WIDTH'(base + p));
            e_end = (p == NPIX - 1);
            if (done_o) n_valid++;
            if (frame_end_o) n_end++;
            if (p < FIRST_OUT) begin
                checks++;
                if (done_o !== 1'b0) begin
                    failures++;
                    $display("FAIL %s done_low p=%0d: got %b expected 0", tag, p, done_o);
                end
            end else begin
                e0 = DATA_WIDTH'(base + p - FIRST_OUT);
                e1 = DATA_WIDTH'(base + p - COLS);
                e2 = DATA_WIDTH'(base + p);
                checks++;
                if (done_o !== 1'b1 || d0_o !== e0 || d1_o !== e1 || d2_o !== e2) begin
                    failures++;
                    $display("FAIL %s triple p=%0d: got done=%b (%0d,%0d,%0d) expected done=1 (%0d,%0d,%0d)",
                             tag, p, done_o, d0_o, d1_o, d2_o, e0, e1, e2);
                end
            end
            checks++;
            if (frame_end_o !== e_end) begin
                failures++;
                $display("FAIL %s frame_end p=%0d: got %b expected %b", tag, p, frame_end_o, e_end);
            end
            if (gaps && (p % 4 == 3) && (p != NPIX - 1)) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, 8'hEE);
                    checks++;
                    if (done_o !== 1'b0 || frame_end_o !== 1'b0) begin
                        failures++;
                        $display("FAIL %s gap_strobe p=%0d g=%0d: got done=%b fe=%b expected 0 0",
                                 tag, p, g, done_o, frame_end_o);
                    end
                    if (p >= FIRST_OUT) begin
                        checks++;
                        if (d0_o !== e0 || d1_o !== e1 || d2_o !== e2) begin
                            failures++;
                            $display("FAIL %s gap_hold p=%0d g=%0d: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                                     tag, p, g, d0_o, d1_o, d2_o, e0, e1, e2);
                        end
                    end
                end
            end
        end
        checks++;
        if (n_valid != NVALID) begin
            failures++;
            $display("FAIL %s valid_count: got %0d expected %0d", tag, n_valid, NVALID);
        end
        checks++;
        if (n_end != 1) begin
            failures++;
            $display("FAIL %s frame_end_count: got %0d expected 1", tag, n_end);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, 8'hFF);
            checks++;
            if (d0_o !== 8'd0 || d1_o !== 8'd0 || d2_o !== 8'd0 ||
                done_o !== 1'b0 || frame_end_o !== 1'b0) begin
                failures++;
                $display("FAIL reset cycle=%0d: got (%0d,%0d,%0d) done=%b fe=%b expected (0,0,0) 0 0",
                         i, d0_o, d1_o, d2_o, done_o, frame_end_o);
            end
        end
        rst    = 1'b1;
        done_i = 1'b0;
    endtask

    // First frame after reset: p=0 must be treated as (0,0), so the first
    // output is exactly (0,6,12) in the cycle after p=12.
    task automatic test_first_output();
        for (int p = 0; p < FIRST_OUT; p++) begin
            drive(1'b1, DATA_WIDTH'(p));
            checks++;
            if (done_o !== 1'b0) begin
                failures++;
                $display("FAIL first_output early p=%0d: got done=%b expected 0", p, done_o);
            end
        end
        drive(1'b1, 8'd12);
        checks++;
        if (done_o !== 1'b1 || d0_o !== 8'd0 || d1_o !== 8'd6 || d2_o !== 8'd12) begin
            failures++;
            $display("FAIL first_output p=12: got done=%b (%0d,%0d,%0d) expected done=1 (0,6,12)",
                     done_o, d0_o, d1_o, d2_o);
        end
        // Finish the frame so the counters end on a frame boundary.
        for (int p = FIRST_OUT + 1; p < NPIX; p++) begin
            drive(1'b1, DATA_WIDTH'(p));
        end
        checks++;
        if (done_o !== 1'b1 || frame_end_o !== 1'b1 ||
            d0_o !== 8'd17 || d1_o !== 8'd23 || d2_o !== 8'd29) begin
            failures++;
            $display("FAIL first_output last: got done=%b fe=%b (%0d,%0d,%0d) expected done=1 fe=1 (17,23,29)",
                     done_o, frame_end_o, d0_o, d1_o, d2_o);
        end
        drive(1'b0, 8'h00);
        checks++;
        if (done_o !== 1'b0 || frame_end_o !== 1'b0) begin
            failures++;
            $display("FAIL first_output after_end: got done=%b fe=%b expected 0 0", done_o, frame_end_o);
        end
    endtask

    task automatic test_full_frame();
        run_frame(0, 1'b0, "full_frame");
        drive(1'b0, 8'h00);
        checks++;
        if (frame_end_o !== 1'b0 || d2_o !== 8'd29) begin
            failures++;
            $display("FAIL full_frame pulse_width: got fe=%b d2=%0d expected fe=0 d2=29", frame_end_o, d2_o);
        end
    endtask

    task automatic test_gaps();
        run_frame(0, 1'b1, "gaps");
    endtask

    task automatic test_back_to_back();
        run_frame(0, 1'b0, "b2b_a");
        run_frame(100, 1'b0, "b2b_b");
    endtask

    task automatic test_mid_reset();
        for (int p = 0; p <= 15; p++) begin
            drive(1'b1, DATA_WIDTH'(200 + p));
        end
        checks++;
        if (done_o !== 1'b1 || d2_o !== 8'd215) begin
            failures++;
            $display("FAIL mid_reset pre: got done=%b d2=%0d expected done=1 d2=215", done_o, d2_o);
        end
        rst = 1'b0;
        drive(1'b1, 8'hFF);
        checks++;
        if (done_o !== 1'b0 || d2_o !== 8'd0 || frame_end_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset during: got done=%b d2=%0d fe=%b expected 0 0 0",
                     done_o, d2_o, frame_end_o);
        end
        rst = 1'b1;
        run_frame(0, 1'b0, "mid_reset");
    endtask

    initial begin
        rst    = 1'b0;
        done_i = 1'b0;
        data_i = '0;
        test_reset();
        test_first_output();
        test_full_frame();
        test_gaps();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
